load_store_unit: RTL and testbench

- Sits directly downstream of the control unit's readMemory/writeMemory/funct3 outputs and the ALU result in the single-cycle core.
- Performs every LB/LH/LW/LBU/LHU/SB/SH/SW against a word-wide data memory that uses a req/ack handshake.
- Stalls the core while an access is in flight.
- Handles byte lanes, sign extension, misalignment, and ack timeout.

---
 rtl/load_store_unit.sv | 167 ++++++++++++++++
 tb/tb_load_store_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Purpose: RV32I load/store path between the execute stage and a req/ack word-wide data memory.
// Latency: 3 cycles minimum (IDLE, ACCESS, DONE); illegal requests fault in the IDLE cycle.
// Backpressure: stall holds the core from request acceptance until DONE; memReq is held until memAck or timeout.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        readMemory,
    input  logic        writeMemory,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] storeData,
    output logic [31:0] loadData,
    output logic        stall,
    output logic        fault,
    output logic        memReq,
    output logic        memWrite,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memByteEnable,
    input  logic [31:0] memRdata,
    input  logic        memAck
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // The wait counter only has to reach TIMEOUT_CYCLES-1; a zero timeout never compares.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [1:0]    lane_off;
    logic [2:0]    acc_f3;
    logic          fault_to;

    logic          req_any;
    logic          bad_f3;
    logic          misaligned;
    logic          illegal;
    logic          legal;
    logic [31:0]   lane_wdata;
    logic [3:0]    lane_be;
    logic [31:0]   rd_shift;
    logic [31:0]   rd_ext;
    logic          timeout_hit;

    // Classify the incoming request; only meaningful while IDLE.
    always_comb begin
        req_any    = readMemory | writeMemory;
        bad_f3     = readMemory ? ((funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7))
                                : (funct3 > 3'd2);
        misaligned = ((funct3[1:0] == 2'b01) && address[0]) ||
                     ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
        illegal    = req_any & ((readMemory & writeMemory) | bad_f3 | misaligned);
        legal      = req_any & ~illegal;
    end

    // Replicate store data across lanes and build the lane enables from the byte offset.
    always_comb begin
        lane_wdata = storeData;
        lane_be    = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                lane_wdata = {4{storeData[7:0]}};
                lane_be    = 4'b0001 << address[1:0];
            end
            2'b01: begin
                lane_wdata = {2{storeData[15:0]}};
                lane_be    = 4'b0011 << address[1:0];
            end
            default: begin
                lane_wdata = storeData;
                lane_be    = 4'b1111;
            end
        endcase
    end

    // Pick the addressed byte/halfword out of the returned word and extend it.
    always_comb begin
        rd_shift = memRdata >> {lane_off, 3'b000};
        case (acc_f3)
            3'd0:    rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd1:    rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd4:    rd_ext = {24'd0, rd_shift[7:0]};
            3'd5:    rd_ext = {16'd0, rd_shift[15:0]};
            default: rd_ext = memRdata;
        endcase
    end

    // Timeout fires on the last allowed ACCESS cycle without an ack.
    always_comb begin
        timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST) && !memAck;
    end

    // Stall is combinational so the core freezes in the same cycle a legal request shows up.
    always_comb begin
        stall = ~reset & (((state == IDLE) & legal) | (state == ACCESS));
        fault = ~reset & ((((state == IDLE) & illegal)) | fault_to);
    end

    // Access sequencer: registers the memory request, counts wait cycles and captures load data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            lane_off      <= 2'b00;
            acc_f3        <= 3'd0;
            fault_to      <= 1'b0;
            loadData      <= 32'd0;
            memReq        <= 1'b0;
            memWrite      <= 1'b0;
            memAddr       <= 32'd0;
            memWdata      <= 32'd0;
            memByteEnable <= 4'b0000;
        end else begin
            fault_to <= 1'b0;
            case (state)
                IDLE: begin
                    if (legal) begin
                        state         <= ACCESS;
                        wait_cnt      <= '0;
                        lane_off      <= address[1:0];
                        acc_f3        <= funct3;
                        memReq        <= 1'b1;
                        memWrite      <= writeMemory;
                        memAddr       <= {address[31:2], 2'b00};
                        memWdata      <= writeMemory ? lane_wdata : 32'd0;
                        memByteEnable <= writeMemory ? lane_be : 4'b0000;
                    end
                end
                ACCESS: begin
                    if (memAck) begin
                        state  <= DONE;
                        memReq <= 1'b0;
                        if (!memWrite) begin
                            loadData <= rd_ext;
                        end
                    end else if (timeout_hit) begin
                        state    <= DONE;
                        memReq   <= 1'b0;
                        fault_to <= 1'b1;
                        if (!memWrite) begin
                            loadData <= 32'd0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // The retiring instruction is still on the inputs; do not restart it.
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    memReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose: directed, table-driven checks of the load/store unit plus timeout and reset-in-flight sequences.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: the bench acts as the memory and chooses how many ACCESS cycles pass before memAck.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        readMemory;
    logic        writeMemory;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] storeData;
    logic [31:0] loadData;
    logic        stall;
    logic        fault;
    logic        memReq;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memByteEnable;
    logic [31:0] memRdata;
    logic        memAck;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .readMemory    (readMemory),
        .writeMemory   (writeMemory),
        .funct3        (funct3),
        .address       (address),
        .storeData     (storeData),
        .loadData      (loadData),
        .stall         (stall),
        .fault         (fault),
        .memReq        (memReq),
        .memWrite      (memWrite),
        .memAddr       (memAddr),
        .memWdata      (memWdata),
        .memByteEnable (memByteEnable),
        .memRdata      (memRdata),
        .memAck        (memAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          delay;   // ACCESS cycles before ack (0 = ack in first ACCESS cycle)
        logic        ill;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic        e_wr;
        logic [31:0] e_load;  // loadData expected after the instruction retires
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] sdata, logic [31:0] rdata, int delay, logic ill,
                                logic [31:0] e_addr, logic [31:0] e_wdata, logic [3:0] e_be,
                                logic e_wr, logic [31:0] e_load);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.delay = delay; v.ill = ill; v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_be = e_be;
        v.e_wr = e_wr; v.e_load = e_load;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  stalls;
        bit  acked;
        string n;
        n = $sformatf("v%0d", idx);
        @(negedge clk);
        readMemory  = v.rd;
        writeMemory = v.wr;
        funct3      = v.f3;
        address     = v.addr;
        storeData   = v.sdata;
        memAck      = 1'b0;
        #1;
        if (v.ill) begin
            chk({n, " fault"}, 32'(fault), 32'd1);
            chk({n, " stall"}, 32'(stall), 32'd0);
            chk({n, " memReq"}, 32'(memReq), 32'd0);
            @(negedge clk);
            readMemory  = 1'b0;
            writeMemory = 1'b0;
            #1;
            chk({n, " memReq after"}, 32'(memReq), 32'd0);
            chk({n, " fault after"}, 32'(fault), 32'd0);
            chk({n, " loadData hold"}, loadData, v.e_load);
            return;
        end
        chk({n, " stall idle"}, 32'(stall), 32'd1);
        chk({n, " fault idle"}, 32'(fault), 32'd0);
        stalls = 1;
        acked  = 1'b0;
        for (int k = 0; k < 8 && !acked; k++) begin
            @(negedge clk);
            memRdata = v.rdata;
            memAck   = (k == v.delay);
            #1;
            if (k == 0) begin
                chk({n, " memReq"}, 32'(memReq), 32'd1);
                chk({n, " memAddr"}, memAddr, v.e_addr);
                chk({n, " memWdata"}, memWdata, v.e_wdata);
                chk({n, " memByteEnable"}, 32'(memByteEnable), 32'(v.e_be));
                chk({n, " memWrite"}, 32'(memWrite), 32'(v.e_wr));
            end
            if (stall) stalls++;
            if (k == v.delay) acked = 1'b1;
        end
        chk({n, " acked in bound"}, 32'(acked), 32'd1);
        @(negedge clk);
        memAck = 1'b0;
        #1;
        chk({n, " done stall"}, 32'(stall), 32'd0);
        chk({n, " done memReq"}, 32'(memReq), 32'd0);
        chk({n, " done fault"}, 32'(fault), 32'd0);
        chk({n, " loadData"}, loadData, v.e_load);
        chk({n, " stall cycles"}, 32'(stalls), 32'(v.delay + 2));
    endtask

    initial begin
        int cnt;
        reset       = 1'b1;
        readMemory  = 1'b0;
        writeMemory = 1'b0;
        funct3      = 3'd0;
        address     = 32'd0;
        storeData   = 32'd0;
        memRdata    = 32'd0;
        memAck      = 1'b0;

        //          rd wr f3   addr       sdata         rdata         dly ill e_addr       e_wdata       e_be     wr e_load
        vecs[0]  = mk(1, 0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 1, 0, 32'h100, 32'h0,        4'b0000, 0, 32'hDEADBEEF);
        vecs[1]  = mk(1, 0, 3'd0, 32'h103, 32'h0,        32'h80FFFFFF, 0, 0, 32'h100, 32'h0,        4'b0000, 0, 32'hFFFFFF80);
        vecs[2]  = mk(1, 0, 3'd4, 32'h103, 32'h0,        32'h80FFFFFF, 0, 0, 32'h100, 32'h0,        4'b0000, 0, 32'h00000080);
        vecs[3]  = mk(1, 0, 3'd5, 32'h102, 32'h0,        32'h80010000, 0, 0, 32'h100, 32'h0,        4'b0000, 0, 32'h00008001);
        vecs[4]  = mk(0, 1, 3'd0, 32'h205, 32'h000000AB, 32'h0,        0, 0, 32'h204, 32'hABABABAB, 4'b0010, 1, 32'h00008001);
        vecs[5]  = mk(0, 1, 3'd1, 32'h206, 32'h1234ABCD, 32'h0,        1, 0, 32'h204, 32'hABCDABCD, 4'b1100, 1, 32'h00008001);
        vecs[6]  = mk(1, 0, 3'd1, 32'h101, 32'h0,        32'h0,        0, 1, 32'h0,   32'h0,        4'b0000, 0, 32'h00008001);
        vecs[7]  = mk(0, 1, 3'd2, 32'h202, 32'h0,        32'h0,        0, 1, 32'h0,   32'h0,        4'b0000, 0, 32'h00008001);
        vecs[8]  = mk(1, 1, 3'd2, 32'h100, 32'h0,        32'h0,        0, 1, 32'h0,   32'h0,        4'b0000, 0, 32'h00008001);
        vecs[9]  = mk(1, 0, 3'd3, 32'h100, 32'h0,        32'h0,        0, 1, 32'h0,   32'h0,        4'b0000, 0, 32'h00008001);
        vecs[10] = mk(0, 1, 3'd4, 32'h100, 32'h0,        32'h0,        0, 1, 32'h0,   32'h0,        4'b0000, 0, 32'h00008001);
        vecs[11] = mk(1, 0, 3'd1, 32'h102, 32'h0,        32'h80010000, 0, 0, 32'h100, 32'h0,        4'b0000, 0, 32'hFFFF8001);
        vecs[12] = mk(0, 1, 3'd2, 32'h300, 32'hCAFEF00D, 32'h0,        0, 0, 32'h300, 32'hCAFEF00D, 4'b1111, 1, 32'hFFFF8001);
        vecs[13] = mk(1, 0, 3'd0, 32'h100, 32'h0,        32'h0000007F, 2, 0, 32'h100, 32'h0,        4'b0000, 0, 32'h0000007F);
        vecs[14] = mk(1, 0, 3'd2, 32'h104, 32'h0,        32'h12345678, 0, 0, 32'h104, 32'h0,        4'b0000, 0, 32'h12345678);

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset loadData", loadData, 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset fault", 32'(fault), 32'd0);
        chk("reset memReq", 32'(memReq), 32'd0);
        chk("reset memAddr", memAddr, 32'd0);
        chk("reset memByteEnable", 32'(memByteEnable), 32'd0);

        // Vectors run back to back: each new instruction appears in the IDLE cycle after DONE.
        for (int i = 0; i < 15; i++) begin
            run_vec(i, vecs[i]);
        end

        // Timeout: load with no ack at all.
        @(negedge clk);
        readMemory  = 1'b1;
        writeMemory = 1'b0;
        funct3      = 3'd2;
        address     = 32'h400;
        memAck      = 1'b0;
        #1;
        chk("to stall idle", 32'(stall), 32'd1);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (!memReq) break;
            cnt++;
        end
        chk("to memReq cycles", 32'(cnt), 32'd4);
        chk("to fault pulse", 32'(fault), 32'd1);
        chk("to loadData zero", loadData, 32'd0);
        chk("to done stall", 32'(stall), 32'd0);
        @(negedge clk);
        readMemory = 1'b0;
        #1;
        chk("to fault cleared", 32'(fault), 32'd0);
        chk("to memReq idle", 32'(memReq), 32'd0);

        // Reset while an access is in flight.
        @(negedge clk);
        readMemory = 1'b1;
        funct3     = 3'd2;
        address    = 32'h500;
        @(negedge clk);
        #1;
        chk("rst memReq access1", 32'(memReq), 32'd1);
        @(negedge clk);
        reset      = 1'b1;
        readMemory = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst memReq dropped", 32'(memReq), 32'd0);
        chk("rst stall dropped", 32'(stall), 32'd0);
        chk("rst no fault", 32'(fault), 32'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (fault || memReq || stall) cnt++;
        end
        chk("rst quiet afterwards", 32'(cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
